// File: rtl/lcd_wr_sched.sv
// Frame-synchronous slot write scheduler: Wishbone writes are queued and drained into the
// LCD slot registers only during vertical blanking. Define LCD_WR_SCHED_FRAMECNT_EN for the frame counter.
module lcd_wr_sched #(
    parameter int DEPTH     = 16,
    parameter int NSLOTS    = 28,
    parameter int V_ACTIVE  = 480,
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_y,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        slot_we,
    output logic [4:0]  slot_idx,
    output logic [13:0] slot_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

    state_t        state;
    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [BW-1:0] budget;
    logic          ack_q, blank_r, en, flush_q, ovf, badidx;
    logic [15:0]   frame_cnt;
    logic          acc, wr, rd, blank, rise, full, empty, pop, q_wr, bad, push;
    logic [31:0]   rdata;

    assign acc   = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr    = acc & wb_we_i;
    assign rd    = acc & ~wb_we_i;
    assign blank = {22'd0, pixel_y} >= V_ACTIVE;
    assign rise  = blank & ~blank_r;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign q_wr  = wr && wb_adr_i[3:2] == 2'd0;
    assign bad   = {27'd0, wb_dat_i[20:16]} >= NSLOTS;
    // Popping stops the moment blank drops so at most one write lands on the first active line.
    assign pop   = state == DRAIN && en && blank && !empty && budget != '0 && !flush_q;
    assign push  = q_wr && !bad && (!full || pop) && !flush_q;

    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;

    always_comb begin
        rdata = '0;
        case (wb_adr_i[3:2])
            2'd1:    rdata = {frame_cnt, 4'd0, badidx, ovf, empty, full, 3'd0, 5'(count)};
            2'd2:    rdata = {31'd0, en};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wb_dat_i[20:16], wb_dat_i[13:0]};
    end

`ifdef LCD_WR_SCHED_FRAMECNT_EN
    always_ff @(posedge clk) begin
        if (reset)     frame_cnt <= '0;
        else if (rise) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ack_q    <= 1'b0;
            wb_dat_o <= '0;
            blank_r  <= 1'b0;
            flush_q  <= 1'b0;
            en       <= 1'b1;
            ovf      <= 1'b0;
            badidx   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            budget   <= '0;
            slot_we  <= 1'b0;
            slot_idx <= '0;
            slot_dat <= '0;
        end else begin
            ack_q    <= acc;
            wb_dat_o <= rd ? rdata : '0;
            blank_r  <= blank;
            flush_q  <= wr && wb_adr_i[3:2] == 2'd2 && wb_dat_i[1];

            if (wr && wb_adr_i[3:2] == 2'd1) begin
                if (wb_dat_i[10]) ovf    <= 1'b0;
                if (wb_dat_i[11]) badidx <= 1'b0;
            end
            if (q_wr && !flush_q) begin
                if (bad)               badidx <= 1'b1;
                else if (full && !pop) ovf    <= 1'b1;
            end
            if (wr && wb_adr_i[3:2] == 2'd2) en <= wb_dat_i[0];

            if (flush_q) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end

            slot_we <= pop;
            if (pop) begin
                slot_idx <= mem[rd_ptr][18:14];
                slot_dat <= mem[rd_ptr][13:0];
            end

            if (!en) state <= IDLE;
            else begin
                case (state)
                    IDLE: if (rise) begin
                        budget <= BW'(BURST_MAX);
                        state  <= DRAIN;
                    end
                    DRAIN: begin
                        if (pop) budget <= budget - 1'b1;
                        if (!blank)             state <= IDLE;
                        else if (budget == '0)  state <= HOLD;
                    end
                    HOLD: if (!blank) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:21], wb_dat_i[15:14]};
endmodule

// File: tb/tb_lcd_wr_sched.sv
// Bench for lcd_wr_sched: register table, directed window sequences, and randomized
// push/drain rounds against a queue-based model of the scheduler.
module tb_lcd_wr_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixel_y = 10'd100;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, slot_we;
    logic [4:0]  slot_idx;
    logic [13:0] slot_dat;

    lcd_wr_sched dut (
        .clk(clk), .reset(reset), .pixel_y(pixel_y),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .slot_we(slot_we), .slot_idx(slot_idx), .slot_dat(slot_dat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [4:0] idx; logic [13:0] dat; int cyc; } pulse_t;
    pulse_t got_q[$];
    always @(negedge clk) if (slot_we === 1'b1) got_q.push_back('{slot_idx, slot_dat, cyc});

    typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic chk; logic [31:0] exp; string nm; } vec_t;
    vec_t tbl[$];

    // Reference model: FIFO contents in order plus the architectural flags.
    logic [18:0] model_q[$];
    logic        m_ovf = 0, m_bad = 0, m_en = 1;
    logic [15:0] m_fc = 0;

    int checks = 0, errors = 0, last_ack_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat, output logic [31:0] rd);
        logic ok = 0;
        rd = '0;
        @(negedge clk);
        wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin ok = 1; rd = wb_dat_o; last_ack_cyc = cyc; end
        end
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        chk("wb_ack", {31'd0, ok}, 32'd1);
        @(posedge clk);
    endtask

    function automatic logic [31:0] exp_status();
        int l = model_q.size();
        logic [15:0] fc = 16'd0;
`ifdef LCD_WR_SCHED_FRAMECNT_EN
        fc = m_fc;
`endif
        return {fc, 4'd0, m_bad, m_ovf, l == 0, l == 16, 3'd0, 5'(l)};
    endfunction

    task automatic check_status(input string nm);
        logic [31:0] rd;
        wb(1'b0, 32'h4, 32'h0, rd);
        chk(nm, rd, exp_status());
    endtask

    task automatic push_entry(input int idx, input logic [13:0] d);
        logic [31:0] rd;
        wb(1'b1, 32'h0, {11'd0, 5'(idx), 2'd0, d}, rd);
        if (idx >= 28)                m_bad = 1;
        else if (model_q.size() == 16) m_ovf = 1;
        else                           model_q.push_back({5'(idx), d});
    endtask

    task automatic write_ctrl(input logic [31:0] v);
        logic [31:0] rd;
        wb(1'b1, 32'h8, v, rd);
        m_en = v[0];
        if (v[1]) model_q.delete();
    endtask

    // Expected drained entries come from the front of the model queue, capped at 8 per window.
    task automatic compare_pulses(input string nm, input int exp_n);
        logic [18:0] e;
        chk({nm, "_count"}, got_q.size(), exp_n);
        for (int i = 0; i < exp_n; i++) begin
            e = model_q.pop_front();
            if (i < got_q.size()) begin
                chk({nm, "_idx"}, {27'd0, got_q[i].idx}, {27'd0, e[18:14]});
                chk({nm, "_dat"}, {18'd0, got_q[i].dat}, {18'd0, e[13:0]});
            end
        end
    endtask

    task automatic window(input string nm, input int w, input logic [9:0] yb, input logic [9:0] ya);
        int n = (model_q.size() > 8) ? 8 : model_q.size();
        if (!m_en) n = 0;
        got_q.delete();
        @(negedge clk); pixel_y = yb;
        repeat (w) @(negedge clk);
        pixel_y = ya;
        repeat (4) @(negedge clk);
        m_fc++;
        compare_pulses(nm, n);
    endtask

    task automatic add(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic c, input logic [31:0] exp, input string nm);
        tbl.push_back('{we, adr, dat, c, exp, nm});
    endtask

    initial begin
        logic [31:0] rd;
        int t0, n;

        add(0, 32'h4, 0, 1, 32'h200, "rst_status");
        add(0, 32'h8, 0, 1, 32'h1,   "rst_ctrl");
        add(0, 32'h0, 0, 1, 32'h0,   "queue_rd");
        add(0, 32'hC, 0, 1, 32'h0,   "reg0c_rd");
        add(1, 32'h0, 32'h00031ABC, 0, 0, "");
        add(0, 32'h4, 0, 1, 32'h001, "level1");
        add(1, 32'h0, 32'h001C0123, 0, 0, "");
        add(0, 32'h4, 0, 1, 32'h801, "badidx_set");
        add(1, 32'h4, 32'h800, 0, 0, "");
        add(0, 32'h4, 0, 1, 32'h001, "badidx_clr");
        add(1, 32'hC, 32'hFFFFFFFF, 0, 0, "");
        add(0, 32'hC, 0, 1, 32'h0,   "reg0c_ign");
        add(1, 32'h8, 32'h0, 0, 0, "");
        add(0, 32'h8, 0, 1, 32'h0,   "en_clr");
        add(1, 32'h8, 32'h3, 0, 0, "");
        add(0, 32'h8, 0, 1, 32'h1,   "flush_rd0");
        add(0, 32'h4, 0, 1, 32'h200, "flush_empty");
        add(1, 32'h0, 32'h001B0005, 0, 0, "");
        add(0, 32'h4, 0, 1, 32'h001, "idx27_ok");
        add(1, 32'h8, 32'h3, 0, 0, "");
        add(0, 32'h4, 0, 1, 32'h200, "flush2_empty");

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",  {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat",  wb_dat_o, 32'd0);
        chk("rst_we",   {31'd0, slot_we}, 32'd0);
        chk("rst_sidx", {27'd0, slot_idx}, 32'd0);
        chk("rst_sdat", {18'd0, slot_dat}, 32'd0);
        reset = 0;

        foreach (tbl[i]) begin
            wb(tbl[i].we, tbl[i].adr, tbl[i].dat, rd);
            if (tbl[i].chk) chk(tbl[i].nm, rd, tbl[i].exp);
        end
        chk("no_slot_we", got_q.size(), 0);

        // Single entry: pulse appears two cycles after pixel_y reaches the blank line.
        push_entry(3, 14'h1ABC);
        check_status("lat_level1");
        got_q.delete();
        @(negedge clk); pixel_y = 10'd480; t0 = cyc;
        repeat (6) @(negedge clk);
        pixel_y = 10'd100;
        repeat (4) @(negedge clk);
        m_fc++;
        if (got_q.size() > 0) chk("lat_cycle", got_q[0].cyc, t0 + 2);
        compare_pulses("lat", 1);
        check_status("lat_level0");

        // Burst cap: 12 queued, 8 per window.
        for (int i = 0; i < 12; i++) push_entry(i, 14'(i * 37 + 5));
        window("burst1", 20, 10'd480, 10'd10);
        check_status("burst_level4");
        window("burst2", 20, 10'd500, 10'd10);
        check_status("burst_empty");

        // Overflow and sticky clear.
        for (int i = 0; i < 17; i++) push_entry(i % 28, 14'(i + 100));
        check_status("ovf_status");
        wb(1'b1, 32'h4, 32'h400, rd); m_ovf = 0;
        check_status("ovf_clr");
        push_entry(28, 14'h3FF);
        check_status("badidx_full");
        write_ctrl(32'h3);
        check_status("flush_full");
        wb(1'b1, 32'h4, 32'h800, rd); m_bad = 0;

        // Flush with 5 queued.
        for (int i = 0; i < 5; i++) push_entry(i + 20, 14'(i));
        write_ctrl(32'h3);
        check_status("flush5");

        // Clearing en mid-drain stops writes within one cycle and holds the level.
        for (int i = 0; i < 10; i++) push_entry(i + 1, 14'(i * 1000));
        got_q.delete();
        @(negedge clk); pixel_y = 10'd480;
        repeat (4) @(negedge clk);
        write_ctrl(32'h0);
        repeat (5) @(negedge clk);
        pixel_y = 10'd100;
        repeat (4) @(negedge clk);
        m_fc++;
        n = got_q.size();
        chk("en_stop_some", {31'd0, n > 0 && n < 8}, 32'd1);
        if (n > 0) chk("en_stop_time", {31'd0, got_q[n-1].cyc <= last_ack_cyc}, 32'd1);
        compare_pulses("en_stop", n);
        check_status("en_stop_level");
        window("en_off", 15, 10'd480, 10'd100);
        check_status("en_off_fc");
        write_ctrl(32'h1);
        window("en_back", 15, 10'd480, 10'd100);
        check_status("en_back_level");

        // Reset in the middle of a drain.
        for (int i = 0; i < 6; i++) push_entry(i, 14'(i + 7));
        @(negedge clk); pixel_y = 10'd480;
        repeat (4) @(negedge clk);
        reset = 1; pixel_y = 10'd100;
        @(negedge clk);
        chk("rst_mid_we", {31'd0, slot_we}, 32'd0);
        reset = 0;
        model_q.delete(); m_ovf = 0; m_bad = 0; m_fc = 0; m_en = 1;
        repeat (3) @(negedge clk);
        got_q.delete();
        check_status("rst_mid_status");
        window("rst_mid_empty", 15, 10'd480, 10'd100);

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            int np = $urandom_range(0, 20);
            logic [31:0] v;
            pixel_y = 10'($urandom_range(0, 479));
            for (int i = 0; i < np; i++) push_entry($urandom_range(0, 31), 14'($urandom_range(0, 16383)));
            check_status("rnd_push");
            v = $urandom & 32'hC00;
            wb(1'b1, 32'h4, v, rd);
            if (v[10]) m_ovf = 0;
            if (v[11]) m_bad = 0;
            check_status("rnd_clr");
            if ($urandom_range(0, 3) == 0) write_ctrl(32'h0);
            window("rnd_win", $urandom_range(12, 30), 10'($urandom_range(480, 524)),
                   10'($urandom_range(0, 479)));
            check_status("rnd_after");
            if (!m_en) write_ctrl(32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
